cdl_crc_16: RTL and testbench
=============================

Name: cdl_crc_16

Overview:
- Serial CRC-16 generator/checker for the USB bulk endpoint datapath, polynomial x^16+x^15+x^2+1 (USB CRC16).
- Consumes one NRZI-decoded, bit-unstuffed data bit per clock, LSB-first per byte.
- Presents the running ones-complemented CRC continuously, for appending on TX or comparing on RX.
- Sits beside the byte shift register in the packet encoder/decoder and is restarted by the controlling FSM at each packet's data phase.

Parameters:
- POLY, 16'h8005, generator polynomial taps excluding the x^16 term, MSB-first form.
- INIT, 16'hFFFF, preset value loaded by reset and by reset_crc.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- input_data  input  1  serial data bit sampled on each rising edge.
- reset_crc  input  1  synchronous restart; loads INIT instead of shifting.
- inverted_crc  output  16  bitwise NOT of the internal CRC register.

Behaviour:
- Internal register crc_q[15:0], MSB-first convention: bit 15 is the x^15 coefficient.
- Reset: rst=1 forces crc_q=INIT immediately, with no clock needed.
  - inverted_crc=16'h0000 while in reset and until the first shift.
- Priority at each rising edge: rst > reset_crc > shift.
- reset_crc=1: crc_q<=INIT; input_data is ignored that cycle.
- Shift, when reset_crc=0, every cycle with no enable:
  - fb = input_data ^ crc_q[15].
  - crc_q <= {crc_q[14:0],1'b0} ^ (fb ? POLY : 16'h0).
- Latency: output reflects the bit sampled at the previous edge, one cycle after sampling.
  - inverted_crc is purely combinational from crc_q, so it is glitch-free relative to clk.
- inverted_crc = ~crc_q at all times.
  - Transmit order of the appended CRC is bit 15 first; the serializer owns that ordering.
- reset_crc held high for many cycles: crc_q stays at INIT.
- rst asserted mid-packet: CRC is discarded and crc_q=INIT on the next observation.
- No saturation or wrap concerns; the shift register is exactly 16 bits and all arithmetic is GF(2) XOR.
- Unknown input_data: no masking. The bench shall not drive X while reset_crc=0.

Optional Feature:
- Macro CDL_CRC_16_CHECK_EN.
- When defined: extra output crc_ok (1 bit, combinational) = (crc_q == 16'h800D), the USB CRC16 residual.
  - crc_ok is high after the receiver has shifted data plus the received CRC field.
  - crc_ok is 0 during reset, since INIT differs from the residual.
- When undefined: port crc_ok does not exist and no comparator is synthesized.

Decomposition:
- Shared package usb_crc_pkg holds:
  - CRC16_POLY=16'h8005.
  - CRC16_INIT=16'hFFFF.
  - CRC16_RESIDUAL=16'h800D.
  - typedef logic [15:0] crc16_t.
- One sub-module is natural: crc16_next, a combinational one-bit LFSR step taking (crc_q, bit) and returning the next crc.
  - It is reused by a future parallel 8-bit variant, which unrolls it 8 times.
- The top holds only the register, priority mux and output inversion.

Test Plan:
- Assert rst asynchronously mid-cycle -> inverted_crc=16'h0000 immediately; holds after release with reset_crc=1.
- After reset, reset_crc=0, shift a single bit 1 -> inverted_crc=16'h0001.
- After reset, reset_crc=0, shift a single bit 0 -> inverted_crc=16'h8004.
- After reset, shift bytes 8'hCC then 8'h33, LSB-first, 16 cycles -> crc_q=16'h28A5, inverted_crc=16'hD75A.
  - Equivalent reflected CRC-16/USB value: 16'h5AEB.
- Shift 5 arbitrary bits, pulse reset_crc one cycle, then repeat the 16-bit stimulus above -> again 16'hD75A.
  - Confirms restart and that reset_crc overrides input_data.
- With CDL_CRC_16_CHECK_EN: shift 8'hCC, 8'h33, then inverted_crc bits 15 down to 0 -> crc_ok=1 exactly after the last bit.
  - Flip any one bit of the stream -> crc_ok=0.

Source files
------------

// File: rtl/usb_crc_pkg.sv
// ============================================================================
//  usb_crc_pkg
//  Shared USB CRC16 constants, type and single-bit LFSR step function.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package usb_crc_pkg;

   typedef logic [15:0] crc16_t;

   localparam crc16_t CRC16_POLY     = 16'h8005;
   localparam crc16_t CRC16_INIT     = 16'hFFFF;
   localparam crc16_t CRC16_RESIDUAL = 16'h800D;

   // One serial step: feedback is the incoming bit XOR the x^15 coefficient.
   function automatic crc16_t crc16_step(input crc16_t crc,
                                         input logic   data_bit,
                                         input crc16_t poly);
      logic fb;
      fb = data_bit ^ crc[15];
      return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
   endfunction

endpackage

`default_nettype wire

// File: rtl/cdl_crc_16_if.sv
// ============================================================================
//  cdl_crc_16_if
//  Serial data / CRC bundle between the packet FSM and the CRC16 block.
//  crc_ok exists only when CDL_CRC_16_CHECK_EN is defined.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface cdl_crc_16_if;

   logic        input_data;
   logic        reset_crc;
   logic [15:0] inverted_crc;
`ifdef CDL_CRC_16_CHECK_EN
   logic        crc_ok;

   modport master (
      output input_data,
      output reset_crc,
      input  inverted_crc,
      input  crc_ok
   );

   modport slave (
      input  input_data,
      input  reset_crc,
      output inverted_crc,
      output crc_ok
   );
`else
   modport master (
      output input_data,
      output reset_crc,
      input  inverted_crc
   );

   modport slave (
      input  input_data,
      input  reset_crc,
      output inverted_crc
   );
`endif

endinterface

`default_nettype wire

// File: rtl/crc16_next.sv
// ============================================================================
//  crc16_next
//  Combinational one-bit CRC16 LFSR step; unrolled by wider variants.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module crc16_next
   import usb_crc_pkg::*;
#(
   parameter crc16_t POLY = CRC16_POLY
) (
   input  crc16_t crc_in,
   input  logic   data_bit,
   output crc16_t crc_out
);

   always_comb begin
      crc_out = crc16_step(crc_in, data_bit, POLY);
   end

endmodule

`default_nettype wire

// File: rtl/cdl_crc_16.sv
// ============================================================================
//  cdl_crc_16
//  Serial USB CRC16 generator/checker, one LSB-first bit per clock.
//  Optional residual checker output enabled by CDL_CRC_16_CHECK_EN.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cdl_crc_16
   import usb_crc_pkg::*;
#(
   parameter crc16_t POLY = CRC16_POLY,
   parameter crc16_t INIT = CRC16_INIT
) (
   input  logic               clk,
   input  logic               rst,
   cdl_crc_16_if.slave        bus
);

   crc16_t crc_q;
   crc16_t crc_next;

   crc16_next #(
      .POLY     (POLY)
   ) u_step (
      .crc_in   (crc_q),
      .data_bit (bus.input_data),
      .crc_out  (crc_next)
   );

   // Restart takes precedence over shifting; input_data is ignored then.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_q <= INIT;
      end else if (bus.reset_crc) begin
         crc_q <= INIT;
      end else begin
         crc_q <= crc_next;
      end
   end

   assign bus.inverted_crc = ~crc_q;

`ifdef CDL_CRC_16_CHECK_EN
   assign bus.crc_ok = (crc_q == CRC16_RESIDUAL);
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdl_crc_16.sv
// ============================================================================
//  tb_cdl_crc_16
//  Directed self-checking bench for cdl_crc_16 with hand-computed CRC values.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cdl_crc_16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   cdl_crc_16_if bus ();

   cdl_crc_16 #(
      .POLY (16'h8005),
      .INIT (16'hFFFF)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Bytes 8'hCC then 8'h33, consumed bit 0 upward (LSB-first per byte).
   logic [15:0] stream = 16'h33CC;
   logic [15:0] crc_field;

   task automatic check_val(input string tag, input logic [15:0] got,
                            input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic shift_bit(input logic b);
      bus.reset_crc  = 1'b0;
      bus.input_data = b;
      @(posedge clk);
      #1;
   endtask

   task automatic restart();
      bus.reset_crc  = 1'b1;
      bus.input_data = 1'b1;
      @(posedge clk);
      #1;
      bus.reset_crc  = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      bus.reset_crc  = 1'b1;
      bus.input_data = 1'b0;
      #1;
      check_val("reset_value", bus.inverted_crc, 16'h0000);
`ifdef CDL_CRC_16_CHECK_EN
      check_val("crc_ok_in_reset", {15'd0, bus.crc_ok}, 16'h0000);
`endif
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_hold", bus.inverted_crc, 16'h0000);

      // Release reset while reset_crc stays high; value must hold at INIT.
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.input_data = i[0];
         @(posedge clk);
         #1;
         check_val("reset_crc_hold", bus.inverted_crc, 16'h0000);
      end

      shift_bit(1'b1);
      check_val("single_one", bus.inverted_crc, 16'h0001);

      restart();
      check_val("restart_value", bus.inverted_crc, 16'h0000);
      shift_bit(1'b0);
      check_val("single_zero", bus.inverted_crc, 16'h8004);

      restart();
      for (int i = 0; i < 8; i++) shift_bit(stream[i]);
      check_val("after_cc", bus.inverted_crc, 16'h0257);
      for (int i = 8; i < 16; i++) shift_bit(stream[i]);
      check_val("cc33", bus.inverted_crc, 16'hD75A);

      // Garbage bits, then a restart driven with input_data=1.
      shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
      shift_bit(1'b1); shift_bit(1'b0);
      restart();
      check_val("restart_override", bus.inverted_crc, 16'h0000);
      for (int i = 0; i < 16; i++) shift_bit(stream[i]);
      check_val("cc33_again", bus.inverted_crc, 16'hD75A);

      // Asynchronous reset asserted mid-cycle during a packet.
      shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_val("async_rst_mid", bus.inverted_crc, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_val("after_rst_release", bus.inverted_crc, 16'h0000);
      shift_bit(1'b1);
      check_val("shift_after_rst", bus.inverted_crc, 16'h0001);

`ifdef CDL_CRC_16_CHECK_EN
      crc_field = 16'hD75A;
      restart();
      for (int i = 0; i < 16; i++) shift_bit(stream[i]);
      for (int i = 15; i > 0; i--) shift_bit(crc_field[i]);
      check_val("crc_ok_early", {15'd0, bus.crc_ok}, 16'h0000);
      shift_bit(crc_field[0]);
      check_val("crc_ok_final", {15'd0, bus.crc_ok}, 16'h0001);
      check_val("residual_inv", bus.inverted_crc, 16'h7FF2);

      restart();
      for (int i = 0; i < 16; i++) shift_bit(i == 4 ? ~stream[i] : stream[i]);
      for (int i = 15; i >= 0; i--) shift_bit(crc_field[i]);
      check_val("crc_ok_flipped", {15'd0, bus.crc_ok}, 16'h0000);
`else
      crc_field = 16'h0000;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
